reg_bank_sequencer: RTL and testbench
=====================================

// Module: reg_bank_sequencer
// PURPOSE
//  Register-bank master for the 8-bit micro: accepts one register-to-register instruction per
//  handshake, drives the bank's read selects (RegXY), captures RX/RY, computes the result and
//  issues one write (R_W/E_N/Dat). It is the only writer of Banco_de_Registros; sits between decode and the bank.
// PARAMETERS
//  READ_WAIT  0  extra cycles RegXY is held before RX/RY are sampled (0 = combinational bank read)
// PORTS
//  Clk         in   1  clock, all state changes on rising edge
//  Rst         in   1  asynchronous, active-high reset
//  Inst_Valid  in   1  instruction fields valid
//  Inst_Ready  out  1  sequencer idle, can accept
//  Opcode      in   3  000 NOP,001 MOV,010 ADD,011 SUB,100 AND,101 OR,110 XOR,111 LDI
//  Rx_Sel      in   3  first source register
//  Ry_Sel      in   3  second source register
//  Rd_Sel      in   3  destination register
//  Imm         in   8  immediate for LDI
//  RX          in   8  bank read port X data
//  RY          in   8  bank read port Y data
//  RegXY       out  6  bank read selects {X[5:3],Y[2:0]}
//  R_W         out  3  bank write address
//  E_N         out  1  bank write enable
//  Dat         out  8  bank write data
//  Done        out  1  one-cycle pulse, instruction retired
//  Z_Flag      out  1  zero flag
//  C_Flag      out  1  carry/borrow flag
// BEHAVIOUR
//  - Reset (async): state IDLE, all outputs and internal regs 0; E_N drops immediately, any write abandoned.
//  - Inst_Ready = (state==IDLE) & ~Rst. Accept when Inst_Valid & Inst_Ready at a rising edge; fields latched.
//  - Inst_Valid while busy is ignored (no queuing); fields need not be held after acceptance.
//  - States: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE.
//    LDI: IDLE -> WRITE -> DONE. NOP: IDLE -> DONE (no write).
//  - READ: RegXY={Rx_Sel,Ry_Sel} held 1+READ_WAIT cycles (down-counter); RX/RY sampled into operand regs
//    at the last READ cycle. RegXY retains value outside READ.
//  - EXEC: 9-bit result = {0,A} op {0,B}. ADD: C=bit8. SUB: A-B mod 256, C=1 when A<B (borrow).
//    AND/OR/XOR: C=0. MOV: result=A.
//  - WRITE: exactly one cycle, E_N=1, R_W=Rd_Sel, Dat=result (LDI: Imm). E_N=0 in every other state.
//    R_W and Dat hold their values after WRITE until the next write.
//  - DONE: Done=1 for one cycle. Latency from accept edge, READ_WAIT=0: ALU/MOV Done in 4th cycle,
//    LDI 2nd, NOP 1st. Each READ_WAIT adds one cycle to ALU/MOV only.
//  - Rd may equal Rx/Ry (operands already captured); back-to-back instructions see prior write (bank writes on WRITE edge).
//  - Accept possible in the cycle after DONE (Inst_Ready high in IDLE).
// CONFIGURATION
//  SEQ_FLAGS_EN defined: Z_Flag/C_Flag registered on the WRITE edge of ADD/SUB/AND/OR/XOR only
//    (Z = result==0); MOV/LDI/NOP leave flags unchanged; reset 0.
//  SEQ_FLAGS_EN undefined: no flag registers; Z_Flag and C_Flag tied 0.
// TESTING (bench instantiates Banco_de_Registros with this block; READ_WAIT=0 unless noted)
//  1 Reset, LDI R1=0x05, LDI R2=0x06 -> each E_N=1 one cycle, R_W=1/2, Dat=05/06; Done 2nd cycle after accept.
//  2 ADD Rx=1,Ry=2,Rd=4 -> RegXY=6'b001010 in READ, Dat=0x0B, R_W=4, Done 4th cycle; Z=0,C=0 (FLAGS_EN).
//  3 SUB R1-R2 -> R5 -> Dat=0xFF, C_Flag=1; then ADD R5+R5->R6 (0xFF+0xFF) -> Dat=0xFE, C=1; XOR R1,R1 -> Dat=0, Z=1.
//  4 Inst_Valid held high with new fields during a busy ADD -> Inst_Ready=0, fields ignored, one Done only.
//  5 Rst asserted mid-WRITE -> E_N=0 same cycle, target register unchanged, Inst_Ready=1 after Rst drops.
//  6 READ_WAIT=2, MOV R4->R7 -> RegXY held 3 cycles, Dat=0x0B, Done 6th cycle; NOP -> no E_N, Done 1st cycle.

Source files
------------

// File: rtl/reg_bank_sequencer.sv
// rtl/reg_bank_sequencer.sv - register-bank master: read, execute, single write per instruction (optional flags: SEQ_FLAGS_EN)
module reg_bank_sequencer #(
    parameter int READ_WAIT = 0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Inst_Valid,
    output logic       Inst_Ready,
    input  logic [2:0] Opcode,
    input  logic [2:0] Rx_Sel,
    input  logic [2:0] Ry_Sel,
    input  logic [2:0] Rd_Sel,
    input  logic [7:0] Imm,
    input  logic [7:0] RX,
    input  logic [7:0] RY,
    output logic [5:0] RegXY,
    output logic [2:0] R_W,
    output logic       E_N,
    output logic [7:0] Dat,
    output logic       Done,
    output logic       Z_Flag,
    output logic       C_Flag
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

    localparam int CW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    state_t          state, state_nxt;
    logic            accept;
    logic [2:0]      op_q;
    logic [2:0]      rd_q;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic [7:0]      alu_res;
    logic [CW-1:0]   wait_cnt;

    assign Inst_Ready = (state == IDLE) & ~Rst;
    assign accept     = Inst_Valid & Inst_Ready;
    assign E_N        = (state == WRITE);
    assign Done       = (state == DONE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (Opcode)
                        OP_NOP:  state_nxt = DONE;
                        OP_LDI:  state_nxt = WRITE;
                        default: state_nxt = READ;
                    endcase
                end
            end
            READ:    if (wait_cnt == '0) state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res = op_a;
        case (op_q)
            OP_MOV:  alu_res = op_a;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            default: alu_res = op_a;
        endcase
    end

    // LDI bypasses READ/EXEC, so its write port values are loaded at accept.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            wait_cnt <= '0;
            RegXY    <= '0;
            R_W      <= '0;
            Dat      <= '0;
        end else begin
            if (accept) begin
                op_q     <= Opcode;
                rd_q     <= Rd_Sel;
                wait_cnt <= CW'(READ_WAIT);
                if (Opcode != OP_NOP && Opcode != OP_LDI)
                    RegXY <= {Rx_Sel, Ry_Sel};
                if (Opcode == OP_LDI) begin
                    R_W <= Rd_Sel;
                    Dat <= Imm;
                end
            end
            if (state == READ) begin
                if (wait_cnt == '0) begin
                    op_a <= RX;
                    op_b <= RY;
                end else begin
                    wait_cnt <= wait_cnt - CW'(1);
                end
            end
            if (state == EXEC) begin
                R_W <= rd_q;
                Dat <= alu_res;
            end
        end
    end

`ifdef SEQ_FLAGS_EN
    logic carry_q;
    logic z_q;
    logic c_q;
    logic is_alu;

    assign is_alu = (op_q >= OP_ADD) && (op_q <= OP_XOR);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            carry_q <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            if (state == EXEC) begin
                if (op_q == OP_ADD)      carry_q <= ({1'b0, op_a} + {1'b0, op_b}) > 9'd255;
                else if (op_q == OP_SUB) carry_q <= (op_a < op_b);
                else                     carry_q <= 1'b0;
            end
            if (state == WRITE && is_alu) begin
                z_q <= (Dat == 8'd0);
                c_q <= carry_q;
            end
        end
    end

    assign Z_Flag = z_q;
    assign C_Flag = c_q;
`else
    assign Z_Flag = 1'b0;
    assign C_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// tb/tb_reg_bank_sequencer.sv - randomized self-checking bench with register bank and reference model
module tb_reg_bank_sequencer;

`ifdef SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] inst_valid;
    logic [2:0] opcode, rx_sel, ry_sel, rd_sel;
    logic [7:0] imm;
    logic [1:0] inst_ready, e_n, done, z_flag, c_flag;
    logic [5:0] regxy [2];
    logic [2:0] r_w   [2];
    logic [7:0] dat   [2];
    logic [7:0] rx    [2];
    logic [7:0] ry    [2];
    logic [7:0] bank0 [8];
    logic [7:0] bank1 [8];

    int checks = 0;
    int errors = 0;
    int mbank [2][8];
    bit mz [2];
    bit mc [2];

    always #5 clk = ~clk;

    reg_bank_sequencer #(.READ_WAIT(0)) dut0 (
        .Clk(clk), .Rst(rst), .Inst_Valid(inst_valid[0]), .Inst_Ready(inst_ready[0]),
        .Opcode(opcode), .Rx_Sel(rx_sel), .Ry_Sel(ry_sel), .Rd_Sel(rd_sel), .Imm(imm),
        .RX(rx[0]), .RY(ry[0]), .RegXY(regxy[0]), .R_W(r_w[0]), .E_N(e_n[0]),
        .Dat(dat[0]), .Done(done[0]), .Z_Flag(z_flag[0]), .C_Flag(c_flag[0]));

    reg_bank_sequencer #(.READ_WAIT(2)) dut1 (
        .Clk(clk), .Rst(rst), .Inst_Valid(inst_valid[1]), .Inst_Ready(inst_ready[1]),
        .Opcode(opcode), .Rx_Sel(rx_sel), .Ry_Sel(ry_sel), .Rd_Sel(rd_sel), .Imm(imm),
        .RX(rx[1]), .RY(ry[1]), .RegXY(regxy[1]), .R_W(r_w[1]), .E_N(e_n[1]),
        .Dat(dat[1]), .Done(done[1]), .Z_Flag(z_flag[1]), .C_Flag(c_flag[1]));

    assign rx[0] = bank0[regxy[0][5:3]];
    assign ry[0] = bank0[regxy[0][2:0]];
    assign rx[1] = bank1[regxy[1][5:3]];
    assign ry[1] = bank1[regxy[1][2:0]];

    always @(posedge clk) begin
        if (e_n[0]) bank0[r_w[0]] <= dat[0];
        if (e_n[1]) bank1[r_w[1]] <= dat[1];
    end

    task automatic wait_ready(input int d);
        for (int i = 0; i < 20 && !inst_ready[d]; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (inst_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout d%0d got %b want 1", d, inst_ready[d]);
        end
    endtask

    task automatic run_inst(input int d, input int op, input int xs, input int ys,
                            input int rd, input int im, input bit busy_noise);
        int  a, b, r, exp_data, exp_lat, rw, nw, ndone, waddr, wdat, wcyc, dcyc, bval;
        bit  exp_wr, c, alu, exp_z, exp_c;
        rw = (d == 1) ? 2 : 0;
        a = mbank[d][xs];
        b = mbank[d][ys];
        r = 0; c = 0; exp_wr = 1'b1;
        case (op)
            0: exp_wr = 1'b0;
            1: r = a;
            2: begin r = a + b; c = (r > 255); end
            3: begin r = a - b; c = (a < b); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = im;
        endcase
        exp_data = (r + 512) % 256;
        exp_lat  = (op == 0) ? 1 : (op == 7) ? 2 : 4 + rw;
        alu      = (op >= 2 && op <= 6);

        wait_ready(d);
        opcode = 3'(op); rx_sel = 3'(xs); ry_sel = 3'(ys); rd_sel = 3'(rd); imm = 8'(im);
        inst_valid[d] = 1'b1;
        @(posedge clk); #1;
        if (!busy_noise) inst_valid[d] = 1'b0;

        nw = 0; ndone = 0; waddr = -1; wdat = -1; wcyc = -1; dcyc = 0;
        for (int cyc = 1; cyc <= exp_lat + 3; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            if (busy_noise && dcyc == 0) begin
                opcode = 3'($urandom); rx_sel = 3'($urandom); ry_sel = 3'($urandom);
                rd_sel = 3'($urandom); imm = 8'($urandom);
            end
            if (cyc == 1) begin
                checks++;
                if (inst_ready[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready d%0d op%0d got %b want 0", d, op, inst_ready[d]);
                end
            end
            if (op >= 1 && op <= 6 && cyc <= 1 + rw) begin
                checks++;
                if (regxy[d] !== {3'(xs), 3'(ys)}) begin
                    errors++;
                    $display("FAIL regxy d%0d cyc%0d got %b want %b", d, cyc, regxy[d], {3'(xs), 3'(ys)});
                end
            end
            if (dcyc != 0 && cyc == dcyc + 1) begin
                checks++;
                if (inst_ready[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_done d%0d got %b want 1", d, inst_ready[d]);
                end
            end
            if (e_n[d] === 1'b1) begin
                nw++; waddr = int'(r_w[d]); wdat = int'(dat[d]); wcyc = cyc;
            end
            if (done[d] === 1'b1) begin
                ndone++;
                if (dcyc == 0) dcyc = cyc;
                inst_valid[d] = 1'b0;
            end
        end
        inst_valid[d] = 1'b0;

        checks++;
        if (ndone != 1 || dcyc != exp_lat) begin
            errors++;
            $display("FAIL done d%0d op%0d got count %0d cycle %0d want count 1 cycle %0d", d, op, ndone, dcyc, exp_lat);
        end
        checks++;
        if (nw != int'(exp_wr)) begin
            errors++;
            $display("FAIL write_count d%0d op%0d got %0d want %0d", d, op, nw, exp_wr);
        end
        if (exp_wr) begin
            checks++;
            if (waddr != rd || wdat != exp_data || wcyc != exp_lat - 1) begin
                errors++;
                $display("FAIL write d%0d op%0d got addr %0d data %0h cyc %0d want addr %0d data %0h cyc %0d",
                         d, op, waddr, wdat, wcyc, rd, exp_data, exp_lat - 1);
            end
            mbank[d][rd] = exp_data;
        end
        bval = (d == 0) ? int'(bank0[rd]) : int'(bank1[rd]);
        checks++;
        if (bval != mbank[d][rd]) begin
            errors++;
            $display("FAIL bank d%0d r%0d got %0h want %0h", d, rd, bval, mbank[d][rd]);
        end
        exp_z = (FLAGS_EN && alu) ? (exp_data == 0) : mz[d];
        exp_c = (FLAGS_EN && alu) ? c : mc[d];
        mz[d] = exp_z;
        mc[d] = exp_c;
        checks++;
        if (z_flag[d] !== exp_z || c_flag[d] !== exp_c) begin
            errors++;
            $display("FAIL flags d%0d op%0d got z%b c%b want z%b c%b", d, op, z_flag[d], c_flag[d], exp_z, exp_c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_valid = 2'b00;
        opcode = '0; rx_sel = '0; ry_sel = '0; rd_sel = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (inst_ready[d] !== 1'b0 || e_n[d] !== 1'b0 || done[d] !== 1'b0 || dat[d] !== 8'd0 ||
                r_w[d] !== 3'd0 || regxy[d] !== 6'd0 || z_flag[d] !== 1'b0 || c_flag[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state d%0d got rdy%b en%b dn%b dat%h rw%h xy%h z%b c%b want all 0",
                         d, inst_ready[d], e_n[d], done[d], dat[d], r_w[d], regxy[d], z_flag[d], c_flag[d]);
            end
            mz[d] = 1'b0;
            mc[d] = 1'b0;
        end
        @(negedge clk) rst = 1'b0;
        #1;
        checks++;
        if (inst_ready !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 11", inst_ready);
        end
    endtask

    task automatic test_ldi();
        run_inst(0, 7, 0, 0, 1, 8'h05, 1'b0);
        run_inst(0, 7, 0, 0, 2, 8'h06, 1'b0);
        foreach (mbank[d, i]) begin
            if (!(d == 0 && (i == 1 || i == 2)))
                run_inst(d, 7, 0, 0, i, (d == 1 && i == 4) ? 8'h0B : int'($urandom_range(0, 255)), 1'b0);
        end
    endtask

    task automatic test_alu();
        run_inst(0, 2, 1, 2, 4, 0, 1'b0);
        run_inst(0, 3, 1, 2, 5, 0, 1'b0);
        run_inst(0, 2, 5, 5, 6, 0, 1'b0);
        run_inst(0, 6, 1, 1, 3, 0, 1'b0);
    endtask

    task automatic test_busy();
        run_inst(0, 2, 3, 4, 7, 0, 1'b1);
        run_inst(1, 3, 6, 2, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        int bval;
        wait_ready(0);
        opcode = 3'd7; rd_sel = 3'd3; imm = 8'(~mbank[0][3]);
        inst_valid[0] = 1'b1;
        @(posedge clk); #1;
        inst_valid[0] = 1'b0;
        checks++;
        if (e_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_write got %b want 1", e_n[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (e_n[0] !== 1'b0 || inst_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_en got en%b rdy%b want en0 rdy0", e_n[0], inst_ready[0]);
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        mz = '{1'b0, 1'b0};
        mc = '{1'b0, 1'b0};
        bval = int'(bank0[3]);
        checks++;
        if (inst_ready[0] !== 1'b1 || bval != mbank[0][3] || dat[0] !== 8'd0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got rdy%b r3=%0h dat%h done%b want rdy1 r3=%0h dat00 done0",
                     inst_ready[0], bval, dat[0], done[0], mbank[0][3]);
        end
    endtask

    task automatic test_read_wait();
        run_inst(1, 1, 4, 0, 7, 0, 1'b0);
        run_inst(1, 0, 2, 3, 5, 0, 1'b0);
        run_inst(0, 0, 1, 1, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 50; n++) begin
            run_inst((n % 5 == 4) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_busy();
        test_reset_mid_write();
        test_read_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
